blob_centroid: RTL and testbench

- Upstream neighbour of `control`. Consumes the per-pixel colour-match mask from the tracker's threshold stage, swept in xvga hcount/vcount order.
- Over one frame it accumulates the pixel count, coordinate sums and bounding box of matched pixels inside the camera window.
- On each frame boundary it divides the sums to produce the centroid and a radius estimate, with a one-cycle valid pulse that drives `control`'s `ready_in`.
- "No target" is signalled as x = y = 9'h1FF, which the top level already maps to centre.

---
 rtl/blob_pkg.sv | 27 ++
 rtl/blob_centroid_seq_divider.sv | 87 ++++++++
 rtl/blob_centroid.sv | 247 ++++++++++++++++++++++++
 tb/tb_blob_centroid.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared types and constants for the blob centroid tracker and its
// sequential divider helper.
package blob_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } blob_state_e;

    localparam logic [8:0] NO_TARGET = 9'h1FF;

    localparam int FRAME_W_DEF    = 320;
    localparam int FRAME_H_DEF    = 240;
    localparam int MIN_PIXELS_DEF = 16;
    localparam int SUM_W_DEF      = 25;
    localparam int CNT_W_DEF      = 17;

    // Half of the larger span; a 9-bit span halved always fits 8 bits,
    // so the 8'hFF ceiling can never be exceeded.
    function automatic logic [7:0] half_span(input logic [8:0] dx, input logic [8:0] dy);
        logic [8:0] m;
        m = (dx > dy) ? dx : dy;
        return m[8:1];
    endfunction

endpackage

// File: rtl/blob_centroid_seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle;
// done pulses N cycles after start is sampled and the quotient then holds.
module seq_divider #(
    parameter int N = 25,
    parameter int D = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [D-1:0] divisor_i,
    output logic [N-1:0] quotient_o,
    output logic         done_o
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0] acc_q, acc_d;
    logic [D-1:0] rem_q, rem_d;
    logic [D-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [D:0]   rem_sh_s;
    logic         fits_s;
    logic [D-1:0] rem_sub_s;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh_s  = {rem_q, acc_q[N-1]};
        fits_s    = (rem_sh_s >= {1'b0, dvs_q});
        rem_sub_s = rem_sh_s[D-1:0] - dvs_q;
    end

    // Next-state: load on start, otherwise iterate while busy.
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            acc_d  = dividend_i;
            dvs_d  = divisor_i;
            rem_d  = '0;
            cnt_d  = CW'(N);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = {acc_q[N-2:0], fits_s};
            rem_d = fits_s ? rem_sub_s : rem_sh_s[D-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = acc_q;
    assign done_o     = done_q;

endmodule

// File: rtl/blob_centroid.sv
// Per-frame accumulation of matched mask pixels; at each vsync rise the
// sums are divided into a centroid and a bounding-box radius is reported.
module blob_centroid
    import blob_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int FRAME_H    = FRAME_H_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF,
    parameter int SUM_W      = SUM_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        vsync_in,
    output logic [8:0]  x_center_out,
    output logic [8:0]  y_center_out,
    output logic [7:0]  radius_out,
    output logic [16:0] count_out,
    output logic        valid_out,
    output logic        overrun_out
);

    localparam int XW = $clog2(FRAME_W);
    localparam int YW = $clog2(FRAME_H);
    localparam int YCW = $clog2(SUM_W + 1);

    logic vsync_q;
    logic edge_s, hit_s;

    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;

    blob_state_e      state_q, state_d;
    logic [YCW-1:0]   cyc_q, cyc_d;
    logic             start_q, start_d;
    logic             empty_q, empty_d;
    logic [SUM_W-1:0] hsum_x_q, hsum_x_d, hsum_y_q, hsum_y_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [XW-1:0]    hxmin_q, hxmin_d, hxmax_q, hxmax_d;
    logic [YW-1:0]    hymin_q, hymin_d, hymax_q, hymax_d;

    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  r_q, r_d;
    logic [16:0] c_q, c_d;
    logic        valid_q, valid_d, ovr_q, ovr_d;

    logic [SUM_W-1:0] qx_s, qy_s;
    logic             dx_done_s, dy_done_s;
    logic [XW-1:0]    span_x_s;
    logic [YW-1:0]    span_y_s;

    // Frame edge and in-window hit detection.
    always_comb begin
        edge_s = vsync_in & ~vsync_q;
        hit_s  = mask_in & (hcount_in < 11'(FRAME_W)) & (vcount_in < 10'(FRAME_H)) & ~edge_s;
    end

    // Accumulators: cleared on every edge, otherwise updated on hits.
    always_comb begin
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        if (edge_s) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            xmin_d  = '1;
            xmax_d  = '0;
            ymin_d  = '1;
            ymax_d  = '0;
        end else if (hit_s) begin
            sum_x_d = sum_x_q + SUM_W'(hcount_in[XW-1:0]);
            sum_y_d = sum_y_q + SUM_W'(vcount_in[YW-1:0]);
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            xmin_d  = (hcount_in[XW-1:0] < xmin_q) ? hcount_in[XW-1:0] : xmin_q;
            xmax_d  = (hcount_in[XW-1:0] > xmax_q) ? hcount_in[XW-1:0] : xmax_q;
            ymin_d  = (vcount_in[YW-1:0] < ymin_q) ? vcount_in[YW-1:0] : ymin_q;
            ymax_d  = (vcount_in[YW-1:0] > ymax_q) ? vcount_in[YW-1:0] : ymax_q;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        span_x_s = hxmax_q - hxmin_q;
        span_y_s = hymax_q - hymin_q;
    end

    // Control FSM: snapshot on edge, fixed-length divide wait, publish.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        start_d  = 1'b0;
        empty_d  = empty_q;
        hsum_x_d = hsum_x_q;
        hsum_y_d = hsum_y_q;
        hcnt_d   = hcnt_q;
        hxmin_d  = hxmin_q;
        hxmax_d  = hxmax_q;
        hymin_d  = hymin_q;
        hymax_d  = hymax_q;
        x_d      = x_q;
        y_d      = y_q;
        r_d      = r_q;
        c_d      = c_q;
        valid_d  = 1'b0;
        ovr_d    = ovr_q | (edge_s & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    hsum_x_d = sum_x_q;
                    hsum_y_d = sum_y_q;
                    hcnt_d   = cnt_q;
                    hxmin_d  = xmin_q;
                    hxmax_d  = xmax_q;
                    hymin_d  = ymin_q;
                    hymax_d  = ymax_q;
                    empty_d  = (cnt_q < CNT_W'(MIN_PIXELS));
                    start_d  = ~(cnt_q < CNT_W'(MIN_PIXELS));
                    cyc_d    = '0;
                    state_d  = ST_DIVIDE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (cyc_q == YCW'(SUM_W)) begin
                    state_d = ST_DONE;
                end else begin
                    cyc_d = cyc_q + YCW'(1);
                end
            end
            ST_DONE: begin
                // Quotients are only trusted in the cycle both dividers report done.
                if (~empty_q & dx_done_s & dy_done_s) begin
                    x_d = (|qx_s[SUM_W-1:9]) ? NO_TARGET : qx_s[8:0];
                    y_d = (|qy_s[SUM_W-1:9]) ? NO_TARGET : qy_s[8:0];
                    r_d = half_span(9'(span_x_s), 9'(span_y_s));
                end else begin
                    x_d = NO_TARGET;
                    y_d = NO_TARGET;
                    r_d = 8'd0;
                end
                c_d     = 17'(hcnt_q);
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    seq_divider #(.N(SUM_W), .D(CNT_W)) u_div_x (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .start_i    (start_q),
        .dividend_i (hsum_x_q),
        .divisor_i  (hcnt_q),
        .quotient_o (qx_s),
        .done_o     (dx_done_s)
    );

    seq_divider #(.N(SUM_W), .D(CNT_W)) u_div_y (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .start_i    (start_q),
        .dividend_i (hsum_y_q),
        .divisor_i  (hcnt_q),
        .quotient_o (qy_s),
        .done_o     (dy_done_s)
    );

    // All state and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vsync_q  <= 1'b0;
            sum_x_q  <= '0;
            sum_y_q  <= '0;
            cnt_q    <= '0;
            xmin_q   <= '1;
            xmax_q   <= '0;
            ymin_q   <= '1;
            ymax_q   <= '0;
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            start_q  <= 1'b0;
            empty_q  <= 1'b0;
            hsum_x_q <= '0;
            hsum_y_q <= '0;
            hcnt_q   <= '0;
            hxmin_q  <= '0;
            hxmax_q  <= '0;
            hymin_q  <= '0;
            hymax_q  <= '0;
            x_q      <= NO_TARGET;
            y_q      <= NO_TARGET;
            r_q      <= 8'd0;
            c_q      <= 17'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            vsync_q  <= vsync_in;
            sum_x_q  <= sum_x_d;
            sum_y_q  <= sum_y_d;
            cnt_q    <= cnt_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            start_q  <= start_d;
            empty_q  <= empty_d;
            hsum_x_q <= hsum_x_d;
            hsum_y_q <= hsum_y_d;
            hcnt_q   <= hcnt_d;
            hxmin_q  <= hxmin_d;
            hxmax_q  <= hxmax_d;
            hymin_q  <= hymin_d;
            hymax_q  <= hymax_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            c_q      <= c_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign x_center_out = x_q;
    assign y_center_out = y_q;
    assign radius_out   = r_q;
    assign count_out    = c_q;
    assign valid_out    = valid_q;
    assign overrun_out  = ovr_q;

endmodule

// File: tb/tb_blob_centroid.sv
// Directed bench for blob_centroid: expected frame results are queued at
// each vsync rise and compared when the valid pulse is due.
module tb_blob_centroid;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        mask_in;
    logic        vsync_in;
    logic [8:0]  x_center_out;
    logic [8:0]  y_center_out;
    logic [7:0]  radius_out;
    logic [16:0] count_out;
    logic        valid_out;
    logic        overrun_out;

    blob_centroid dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .mask_in      (mask_in),
        .vsync_in     (vsync_in),
        .x_center_out (x_center_out),
        .y_center_out (y_center_out),
        .radius_out   (radius_out),
        .count_out    (count_out),
        .valid_out    (valid_out),
        .overrun_out  (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [7:0]  r;
        logic [16:0] c;
    } res_t;

    localparam res_t RESET_RES = '{x: 9'h1FF, y: 9'h1FF, r: 8'd0, c: 17'd0};

    res_t sb[$];
    res_t last_res;
    logic exp_ovr;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic pix(input int hh, input int vv);
        hcount_in = 11'(hh);
        vcount_in = 10'(vv);
        mask_in   = 1'b1;
        tick();
        mask_in   = 1'b0;
    endtask

    task automatic square(input int x0, input int y0, input int w, input int hgt);
        for (int yy = y0; yy < y0 + hgt; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                pix(xx, yy);
    endtask

    // Vsync rise with an in-window pixel that must be discarded.
    task automatic rise(input res_t e, input bit push);
        vsync_in  = 1'b1;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        mask_in   = 1'b1;
        tick();
        vsync_in  = 1'b0;
        mask_in   = 1'b0;
        if (push) sb.push_back(e);
    endtask

    // Waits the fixed 27 cycles; optionally dirties the next frame and
    // raises a second vsync at cycle second_at.
    task automatic await_result(input string tag, input int second_at);
        res_t e;
        int   early;
        early = 0;
        for (int k = 1; k <= 27; k++) begin
            if (second_at > 0 && k < second_at) begin
                hcount_in = 11'd5;
                vcount_in = 10'd5;
                mask_in   = 1'b1;
            end
            if (k == second_at) vsync_in = 1'b1;
            tick();
            vsync_in = 1'b0;
            mask_in  = 1'b0;
            if (k < 27) begin
                if (valid_out !== 1'b0 || x_center_out !== last_res.x ||
                    radius_out !== last_res.r || count_out !== last_res.c)
                    early++;
            end
        end
        chk({tag, "_quiet"}, 32'(early), 32'd0);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_x"}, 32'(x_center_out), 32'(e.x));
            chk({tag, "_y"}, 32'(y_center_out), 32'(e.y));
            chk({tag, "_r"}, 32'(radius_out), 32'(e.r));
            chk({tag, "_c"}, 32'(count_out), 32'(e.c));
            chk({tag, "_ovr"}, 32'(overrun_out), 32'(exp_ovr));
            last_res = e;
        end
        tick();
        chk({tag, "_pulse"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        int vcnt;
        rst_in    = 1'b1;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        mask_in   = 1'b0;
        vsync_in  = 1'b0;
        exp_ovr   = 1'b0;
        last_res  = RESET_RES;
        tick();
        tick();
        chk("rst_x", 32'(x_center_out), 32'h1FF);
        chk("rst_y", 32'(y_center_out), 32'h1FF);
        chk("rst_r", 32'(radius_out), 32'd0);
        chk("rst_c", 32'(count_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ovr", 32'(overrun_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // 4x4 square at (100..103, 50..53).
        square(100, 50, 4, 4);
        rise('{x: 9'd101, y: 9'd51, r: 8'd1, c: 17'd16}, 1'b1);
        await_result("sq4", 0);

        // Empty frame.
        rise('{x: 9'h1FF, y: 9'h1FF, r: 8'd0, c: 17'd0}, 1'b1);
        await_result("empty", 0);

        // Out-of-window hits (including first column/row beyond the window) plus 15 pixels.
        pix(500, 10);
        pix(10, 300);
        pix(500, 300);
        pix(320, 0);
        pix(0, 240);
        for (int i = 0; i < 15; i++) pix(20 + i, 100);
        rise('{x: 9'h1FF, y: 9'h1FF, r: 8'd0, c: 17'd15}, 1'b1);
        await_result("oow15", 0);

        // Whole 320x240 window.
        square(0, 0, 320, 240);
        rise('{x: 9'd159, y: 9'd119, r: 8'd159, c: 17'd76800}, 1'b1);
        await_result("full", 0);

        // 2x8 block, then a second vsync 10 cycles after the first.
        square(200, 10, 2, 8);
        rise('{x: 9'd200, y: 9'd13, r: 8'd3, c: 17'd16}, 1'b1);
        exp_ovr = 1'b1;
        await_result("ovr", 10);
        rise('{x: 9'h1FF, y: 9'h1FF, r: 8'd0, c: 17'd0}, 1'b1);
        await_result("ovr_next", 0);

        // Reset during the divide phase.
        square(100, 50, 4, 4);
        rise(RESET_RES, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        rst_in = 1'b1;
        #1;
        chk("mid_rst_x", 32'(x_center_out), 32'h1FF);
        chk("mid_rst_y", 32'(y_center_out), 32'h1FF);
        chk("mid_rst_c", 32'(count_out), 32'd0);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_ovr", 32'(overrun_out), 32'd0);
        tick();
        rst_in   = 1'b0;
        exp_ovr  = 1'b0;
        last_res = RESET_RES;
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (valid_out !== 1'b0) vcnt++;
        end
        chk("post_rst_no_valid", 32'(vcnt), 32'd0);
        square(60, 30, 4, 4);
        rise('{x: 9'd61, y: 9'd31, r: 8'd1, c: 17'd16}, 1'b1);
        await_result("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
